// File: rtl/pipe_share_arb.sv
// pipe_share_arb: round-robin sharing of one fixed-latency, no-stall register
// pipeline among NREQ requesters. A tag shift register follows each in-flight
// slot so the pipeline tail can be steered back to its owner as a response
// pulse. An IDLE/RUN/DRAIN FSM lets the owner quiesce the pipeline.
//
// Optional build macro: PIPE_SHARE_STATS_EN
//   defined   -> per-requester saturating 16-bit grant counters on grant_cnt
//   undefined -> grant_cnt tied to zero, no counter flops
module pipe_share_arb #(
    parameter int NREQ     = 2,
    parameter int PIPE_LAT = 2,
    parameter int DW       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        pipe_din,
    input  logic [DW-1:0]        pipe_dout,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy,
    output logic                 idle,
    output logic [NREQ*16-1:0]   grant_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                        state_q;
    logic   [IW-1:0]               rr_ptr_q, rr_ptr_d;
    logic   [PIPE_LAT-1:0]         tag_vld_q, tag_vld_d;
    logic   [PIPE_LAT-1:0][IW-1:0] tag_id_q, tag_id_d;

    logic                          grant_en;
    logic                          grant_any;
    logic   [IW-1:0]               grant_idx;

    // Grants only while running and still enabled; en falling in RUN
    // suppresses the grant in that same cycle.
    assign grant_en = (state_q == S_RUN) && en;

    // Round-robin search starting at rr_ptr, ascending with wrap.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (grant_en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NREQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = IW'(idx);
                end
            end
        end
    end

    // One-hot ready, head payload mux and pointer advance past the winner.
    always_comb begin
        req_ready = '0;
        pipe_din  = '0;
        rr_ptr_d  = rr_ptr_q;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            pipe_din             = req_data[grant_idx*DW +: DW];
            rr_ptr_d             = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Tag chain mirrors the pipeline: entry 0 records this cycle's grant.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = grant_any;
        tag_id_d[0]  = grant_idx;
        for (int k = 1; k < PIPE_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    // Arbiter pointer and tag chain state; reset discards in-flight tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Enable/drain FSM; DRAIN always runs to an empty pipeline before IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (en) state_q <= S_RUN;
                S_RUN:   if (!en) state_q <= S_DRAIN;
                S_DRAIN: if (tag_vld_d == '0) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Steer the pipeline tail back to the owner of the oldest slot.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_vld_q[PIPE_LAT-1] && (tag_id_q[PIPE_LAT-1] == IW'(i));
        end
    end

    assign rsp_data = pipe_dout;
    assign busy     = |tag_vld_q;
    assign idle     = (state_q == S_IDLE) && !busy;

`ifdef PIPE_SHARE_STATS_EN
    logic [NREQ-1:0][15:0] cnt_q, cnt_d;

    // Saturating per-requester grant counters.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (grant_idx == IW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter state, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_share_arb.sv
// Directed bench for pipe_share_arb (NREQ=2, PIPE_LAT=2, DW=4). The bench
// models the external pipeline as a two-register chain from pipe_din to
// pipe_dout. Inputs change just after the falling edge; outputs are sampled
// 1 time unit later, well away from the rising edge.
module tb_pipe_share_arb;

    localparam int NREQ     = 2;
    localparam int PIPE_LAT = 2;
    localparam int DW       = 4;

    logic                clk;
    logic                rst;
    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [DW-1:0]       pipe_din;
    logic [DW-1:0]       pipe_dout;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                busy;
    logic                idle;
    logic [NREQ*16-1:0]  grant_cnt;

    int checks = 0;
    int errors = 0;

    pipe_share_arb #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pipe_din  (pipe_din),
        .pipe_dout (pipe_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .idle      (idle),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared pipeline: two plain register stages.
    logic [DW-1:0] p1, p2;
    always @(posedge clk) begin
        p1 <= pipe_din;
        p2 <= p1;
    end
    assign pipe_dout = p2;

    // Reset, then enable with one IDLE cycle; returns just before cycle 0 of RUN.
    task automatic do_start();
        rst = 1'b1; en = 1'b0; req_valid = '0; req_data = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; req_valid = 2'b11; req_data = 8'h21;
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp got %b exp 00", rsp_valid); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
        checks++; if (pipe_din !== 4'h0) begin errors++; $display("FAIL reset_din got %h exp 0", pipe_din); end
        checks++; if (grant_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", grant_cnt); end
    endtask

    task automatic test_single();
        do_start();
        req_valid = 2'b01; #1;   // IDLE cycle: no grant even with a request
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_idle_ready got %b exp 00", req_ready); end
        @(negedge clk); req_valid = 2'b01; req_data = 8'h0A; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        checks++; if (pipe_din !== 4'hA)   begin errors++; $display("FAIL single_din got %h exp a", pipe_din); end
        @(negedge clk); req_valid = 2'b00; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_early got %b exp 00", rsp_valid); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp got %b exp 01", rsp_valid); end
        checks++; if (rsp_data !== 4'hA)   begin errors++; $display("FAIL single_rsp_data got %h exp a", rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_late got %b exp 00", rsp_valid); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g;
        logic [1:0] exp_r;
        logic [3:0] exp_d;
        do_start();
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            req_data  = 8'h21;
            #1;
            exp_g = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL alt_ready c%0d got %b exp %b", c, req_ready, exp_g); end
            if (c >= 2) begin
                exp_r = ((c - 2) % 2 == 0) ? 2'b01 : 2'b10;
                exp_d = ((c - 2) % 2 == 0) ? 4'h1 : 4'h2;
                checks++; if (rsp_valid !== exp_r) begin errors++; $display("FAIL alt_rsp c%0d got %b exp %b", c, rsp_valid, exp_r); end
                checks++; if (rsp_data !== exp_d)  begin errors++; $display("FAIL alt_rsp_data c%0d got %h exp %h", c, rsp_data, exp_d); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            req_valid = 2'b10; req_data = 8'h50; #1;
            checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL b2b_ready c%0d got %b exp 10", c, req_ready); end
            @(negedge clk);
        end
        req_valid = 2'b11; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_wrap got %b exp 01", req_ready); end
        // r1 responses arrive from the three back-to-back grants
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL b2b_rsp got %b exp 10", rsp_valid); end
        checks++; if (rsp_data !== 4'h5)   begin errors++; $display("FAIL b2b_rsp_data got %h exp 5", rsp_data); end
        @(negedge clk); req_valid = 2'b00;
    endtask

    task automatic test_drain();
        do_start();
        @(negedge clk);
        req_valid = 2'b01; req_data = 8'h03;
        @(negedge clk);   // grants in two consecutive cycles
        @(negedge clk);
        en = 1'b0; #1;    // still RUN, but en low suppresses the grant
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drain_nogrant got %b exp 00", req_ready); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL drain_busy0 got %b exp 1", busy); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL drain_rsp0 got %b exp 01", rsp_valid); end
        @(negedge clk); en = 1'b1; #1;    // DRAIN: en ignored
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drain_ready1 got %b exp 00", req_ready); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL drain_busy1 got %b exp 1", busy); end
        checks++; if (idle !== 1'b0)       begin errors++; $display("FAIL drain_idle1 got %b exp 0", idle); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL drain_rsp1 got %b exp 01", rsp_valid); end
        @(negedge clk); #1;               // back in IDLE, pipeline empty
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL drain_busy2 got %b exp 0", busy); end
        checks++; if (idle !== 1'b1)       begin errors++; $display("FAIL drain_idle2 got %b exp 1", idle); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL drain_ready2 got %b exp 00", req_ready); end
        @(negedge clk); #1;               // RUN again
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL drain_rerun got %b exp 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; en = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_start();
        @(negedge clk); req_valid = 2'b01; req_data = 8'h76;
        @(negedge clk); req_valid = 2'b10;
        @(negedge clk); req_valid = 2'b00; en = 1'b0; #1;
        rst = 1'b1; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_rsp got %b exp 00", rsp_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (idle !== 1'b1)       begin errors++; $display("FAIL rstmid_idle got %b exp 1", idle); end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rstmid_late c%0d got %b exp 00", c, rsp_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_stats();
        do_start();
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 5) ? 2'b01 : 2'b10; req_data = 8'h11;
            @(negedge clk);
        end
        req_valid = 2'b00; #1;
`ifdef PIPE_SHARE_STATS_EN
        checks++; if (grant_cnt !== {16'd3, 16'd5}) begin errors++; $display("FAIL stats_cnt got %h exp 00030005", grant_cnt); end
`else
        checks++; if (grant_cnt !== 32'h0) begin errors++; $display("FAIL stats_off got %h exp 0", grant_cnt); end
`endif
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_back_to_back();
        test_drain();
        test_reset_midflight();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_share_arb.md
Name: pipe_share_arb

Overview:
- Shares one fixed-latency register pipeline (a chain of PIPE_LAT back-to-back single-register stages, DW bits wide, no stall) among NREQ requesters.
- Each cycle, a round-robin arbiter grants at most one valid request and drives its payload into the pipeline head.
- A tag shift register tracks the owner of each in-flight slot and steers the pipeline tail back to the owning requester as a response pulse.
- An enable/drain FSM lets the owner quiesce the shared pipeline cleanly before reconfiguring or gating it.

Parameters:
- NREQ, 2, number of requesters (2..8)
- PIPE_LAT, 2, cycles from pipe_din sample to matching pipe_dout (>=1)
- DW, 4, payload width (the d0/d1/d2 bundle flattened: {d2[1:0], d1, d0})

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  level; 1 = arbitrate, 0 = stop granting and drain
- req_valid  input  NREQ  per-requester request
- req_data  input  NREQ*DW  per-requester payload, requester i at [i*DW +: DW]
- req_ready  output  NREQ  one-hot/zero grant; transfer when req_valid[i] & req_ready[i]
- pipe_din  output  DW  to pipeline head
- pipe_dout  input  DW  from pipeline tail
- rsp_valid  output  NREQ  one-hot/zero response pulse
- rsp_data  output  DW  equals pipe_dout (qualified by rsp_valid)
- busy  output  1  any slot in flight
- idle  output  1  FSM in IDLE and pipeline empty
- grant_cnt  output  NREQ*16  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset (async assert): state=IDLE, rr_ptr=0, all tag_vld=0, tag_id=0, grant_cnt=0. Hence req_ready=0, rsp_valid=0, busy=0, idle=1, pipe_din=0.
- FSM states IDLE, RUN, DRAIN:
  - IDLE -> RUN when en=1 (no grants in the IDLE cycle itself).
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when all tag_vld=0 after the edge. DRAIN always completes; en=1 during DRAIN is ignored until IDLE.
- Grants occur only in RUN:
  - Search req_valid starting at index rr_ptr, ascending with wrap.
  - The first valid index g gets req_ready[g]=1 (combinational from req_valid, state and rr_ptr). At most one ready per cycle.
  - If any grant, rr_ptr <= (g+1) mod NREQ on the edge; otherwise rr_ptr holds.
- pipe_din = req_data[g] when granted, else 0.
- Tag shift register, PIPE_LAT entries of {vld, id[clog2(NREQ)]}:
  - Entry 0 <= {grant_any, g}; entry k <= entry k-1 every cycle, unconditionally.
- Response: rsp_valid[i] = tag_vld[PIPE_LAT-1] & (tag_id[PIPE_LAT-1]==i); rsp_data = pipe_dout.
- Latency: a grant in cycle t gives its response in cycle t+PIPE_LAT. Throughput is 1 per cycle; no response backpressure, so requesters must accept rsp_valid unconditionally.
- busy = OR of all tag_vld. idle = (state==IDLE) & ~busy.
- req_valid may drop without a grant (no hold requirement); an ungranted request is simply not transferred.
- Simultaneous en falling and a valid request: no grant that cycle, since the FSM is still in RUN but en=0 suppresses the grant. Grant condition = (state==RUN) & en.
- Reset mid-operation: in-flight tags are discarded immediately and no responses are produced for them. The pipeline's own contents become don't-care.

Optional Feature:
- Macro PIPE_SHARE_STATS_EN.
- Defined: grant_cnt[i] increments by 1 on every grant to requester i, saturating at 16'hFFFF; cleared only by rst.
- Undefined: grant_cnt is driven constant 0 and no counter flops exist. The port is present in both builds.

Test Plan:
- Reset, en=1, req_valid=2'b01, req_data[0]=4'hA for 1 cycle after RUN -> req_ready=2'b01 in that cycle; rsp_valid=2'b01, rsp_data=4'hA exactly 2 cycles later.
- Both valid for 4 consecutive cycles, data r0=4'h1, r1=4'h2 -> grants 0,1,0,1; rsp_valid sequence 01,10,01,10 starting 2 cycles after the first grant; rsp_data alternates 1,2.
- Back-to-back r1-only for 3 cycles, then both valid -> grant goes to r0 next (rr_ptr wrapped to 0).
- en 1->0 with 2 grants in flight -> no further req_ready; state DRAIN; busy=1 for 2 cycles; then idle=1; en=1 during drain has no effect until IDLE.
- rst asserted asynchronously with tags in flight -> rsp_valid=0 and busy=0 immediately, with no late responses after release.
- With PIPE_SHARE_STATS_EN: 5 grants to r0, 3 to r1 -> grant_cnt = {16'd3, 16'd5}. Force the counter to 16'hFFFE, grant twice -> value holds at 16'hFFFF.
